// File: rtl/sb_pkg.sv
// Shared types and helpers for the post-commit store buffer.
package sb_pkg;

  typedef enum logic {SB_IDLE, SB_ISSUE} sb_state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  bm;
  } sb_entry_t;

  localparam logic [3:0] LEGAL_BM_B0 = 4'b0001;
  localparam logic [3:0] LEGAL_BM_B1 = 4'b0010;
  localparam logic [3:0] LEGAL_BM_B2 = 4'b0100;
  localparam logic [3:0] LEGAL_BM_B3 = 4'b1000;
  localparam logic [3:0] LEGAL_BM_H0 = 4'b0011;
  localparam logic [3:0] LEGAL_BM_H1 = 4'b1100;
  localparam logic [3:0] LEGAL_BM_W  = 4'b1111;

  // Only naturally aligned byte/half/word masks are storable; the cache
  // derives the access size from the mask.
  function automatic logic legal_bm(input logic [3:0] bm);
    return bm inside {LEGAL_BM_B0, LEGAL_BM_B1, LEGAL_BM_B2, LEGAL_BM_B3,
                      LEGAL_BM_H0, LEGAL_BM_H1, LEGAL_BM_W};
  endfunction

  function automatic logic [31:0] bm_expand(input logic [3:0] bm);
    return {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Commit-side enqueue, cache store port and load-forwarding lookup of the store buffer.
interface store_buffer_if;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [29:0] enq_address_i;
  logic [31:0] enq_data_i;
  logic [3:0]  enq_bm_i;
  logic        store_valid_o;
  logic [29:0] store_address_o;
  logic [31:0] store_data_o;
  logic [3:0]  store_bm_o;
  logic        cache_done_i;
  logic [29:0] fwd_address_i;
  logic [3:0]  fwd_bm_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic        fwd_conflict_o;
  logic        sb_empty_o;

  modport slave (
    input  enq_valid_i, enq_address_i, enq_data_i, enq_bm_i, cache_done_i,
           fwd_address_i, fwd_bm_i,
    output enq_ready_o, store_valid_o, store_address_o, store_data_o, store_bm_o,
           fwd_hit_o, fwd_data_o, fwd_conflict_o, sb_empty_o
  );

  modport master (
    output enq_valid_i, enq_address_i, enq_data_i, enq_bm_i, cache_done_i,
           fwd_address_i, fwd_bm_i,
    input  enq_ready_o, store_valid_o, store_address_o, store_data_o, store_bm_o,
           fwd_hit_o, fwd_data_o, fwd_conflict_o, sb_empty_o
  );
endinterface

// File: rtl/sb_fwd_match.sv
// Combinational youngest-entry search for store-to-load forwarding.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PTR_W-1:0] tail,
  input  logic [29:0]      lk_addr,
  input  logic [3:0]       lk_bm,
  output logic             hit,
  output logic             conflict,
  output logic [31:0]      data
);

  logic             found;
  logic [3:0]       f_bm;
  logic [31:0]      f_data;
  logic [PTR_W-1:0] idx;
  logic             covered;

  // Scanning from tail walks oldest to youngest, so the last match wins.
  always_comb begin
    found  = 1'b0;
    f_bm   = '0;
    f_data = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail + PTR_W'(k);
      if (valid[idx] && entries[idx].addr == lk_addr && (entries[idx].bm & lk_bm) != '0) begin
        found  = 1'b1;
        f_bm   = entries[idx].bm;
        f_data = entries[idx].data;
      end
    end
    covered  = (f_bm & lk_bm) == lk_bm;
    hit      = found && covered;
    conflict = found && !covered;
    data     = hit ? (f_data & bm_expand(lk_bm)) : '0;
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store queue feeding the data-cache store port, with load forwarding.
// Optional write merging into the youngest entry: define STORE_BUF_MERGE_EN.
module store_buffer
  import sb_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           cpu_clock_i,
  input  logic           cpu_resetn_i,
  store_buffer_if.slave  sb
);

  sb_entry_t        mem [DEPTH];
  sb_entry_t        out_q, load_entry, wr_entry, new_entry;
  sb_state_t        state_q, state_d;
  logic [PTR_W-1:0] head_q, tail_q, next_head, wr_idx;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid;
  logic             full, enq_ready, enq_fire, pop, alloc, merge, load_out;

  assign full      = count_q == (PTR_W+1)'(DEPTH);
  assign new_entry = '{addr: sb.enq_address_i, data: sb.enq_data_i, bm: sb.enq_bm_i};

`ifdef STORE_BUF_MERGE_EN
  logic [PTR_W-1:0] young_idx;
  sb_entry_t        young;
  logic [31:0]      enq_mask;

  assign young_idx = tail_q - PTR_W'(1);
  assign young     = mem[young_idx];
  assign enq_mask  = bm_expand(sb.enq_bm_i);
  assign merge     = (count_q != '0) && !(state_q == SB_ISSUE && young_idx == head_q)
                   && young.addr == sb.enq_address_i && legal_bm(young.bm | sb.enq_bm_i);
  assign enq_ready = !full || merge;
  assign wr_idx    = merge ? young_idx : tail_q;
  assign wr_entry  = merge ? '{addr: young.addr,
                               data: (young.data & ~enq_mask) | (sb.enq_data_i & enq_mask),
                               bm:   young.bm | sb.enq_bm_i}
                           : new_entry;
`else
  assign merge     = 1'b0;
  assign enq_ready = !full;
  assign wr_idx    = tail_q;
  assign wr_entry  = new_entry;
`endif

  assign enq_fire  = sb.enq_valid_i && enq_ready;
  assign alloc     = enq_fire && !merge;
  assign pop       = (state_q == SB_ISSUE) && sb.cache_done_i;
  assign count_d   = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
  assign next_head = pop ? head_q + PTR_W'(1) : head_q;
  // The entry written on this edge may be the one about to be presented.
  assign load_entry = (enq_fire && wr_idx == next_head) ? wr_entry : mem[next_head];

  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    unique case (state_q)
      SB_IDLE: begin
        if (count_q != '0) begin
          state_d  = SB_ISSUE;
          load_out = 1'b1;
        end
      end
      SB_ISSUE: begin
        if (pop) begin
          if (count_d != '0) load_out = 1'b1;
          else               state_d  = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (enq_fire) mem[wr_idx] <= wr_entry;
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      state_q <= SB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop)      head_q <= head_q + PTR_W'(1);
      if (alloc)    tail_q <= tail_q + PTR_W'(1);
      if (load_out) out_q  <= load_entry;
    end
  end

  assign sb.enq_ready_o     = enq_ready;
  assign sb.store_valid_o   = state_q == SB_ISSUE;
  assign sb.store_address_o = out_q.addr;
  assign sb.store_data_o    = out_q.data;
  assign sb.store_bm_o      = out_q.bm;
  assign sb.sb_empty_o      = count_q == '0;

  sb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
    .entries  (mem),
    .valid    (valid),
    .tail     (tail_q),
    .lk_addr  (sb.fwd_address_i),
    .lk_bm    (sb.fwd_bm_i),
    .hit      (sb.fwd_hit_o),
    .conflict (sb.fwd_conflict_o),
    .data     (sb.fwd_data_o)
  );

  a_done_in_idle: assert property (@(posedge cpu_clock_i) disable iff (!cpu_resetn_i)
    !(state_q == SB_IDLE && sb.cache_done_i));
  a_legal_bm: assert property (@(posedge cpu_clock_i) disable iff (!cpu_resetn_i)
    enq_fire |-> legal_bm(sb.enq_bm_i));

endmodule
